// File: rtl/ternary_mvm_pkg.sv
// rtl/ternary_mvm_pkg.sv - shared states, command/weight codes and width helpers for ternary_mvm_core
package ternary_mvm_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN
   } state_e;

   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_RUN  = 2'b10;

   localparam logic [1:0] W_POS  = 2'b01;
   localparam logic [1:0] W_NEG  = 2'b11;
   localparam logic [1:0] W_ZERO = 2'b00;

   // Sign bit plus log2(IN_LEN) growth bits: a full-length sum of +/-x never overflows.
   function automatic int calc_acc_w(input int bit_width, input int in_len);
      return bit_width + $clog2(in_len) + 1;
   endfunction

   function automatic int calc_nbeats(input int in_len, input int out_len);
      return in_len * out_len / 8;
   endfunction

endpackage

// File: rtl/ternary_mac_row.sv
// rtl/ternary_mac_row.sv - one ternary multiply-accumulate row (acc += w*x, w in {-1,0,+1})
module ternary_mac_row
   import ternary_mvm_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int ACC_W     = 13
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  w_code,
   input  logic signed [BIT_WIDTH-1:0] x,
   input  logic                        clear,
   input  logic                        en,
   output logic signed [ACC_W-1:0]     acc
);

   logic signed [ACC_W-1:0] x_ext;

   assign x_ext = ACC_W'(x);

   // Reserved code 2'b10 falls through with zero, so the accumulator holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         case (w_code)
            W_POS:   acc <= acc + x_ext;
            W_NEG:   acc <= acc - x_ext;
            default: acc <= acc;
         endcase
      end
   end

endmodule

// File: rtl/ternary_mvm_core.sv
// rtl/ternary_mvm_core.sv - ternary matrix-vector engine: FSM, weight store, MAC rows, saturating output
// Optional: define TERNARY_MVM_RELU_EN to clamp negative results to zero.
module ternary_mvm_core
   import ternary_mvm_pkg::*;
#(
   parameter int IN_LEN    = 16,
   parameter int OUT_LEN   = 8,
   parameter int BIT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   input  logic [1:0]                  cmd,
   output logic                        cmd_ready,
   input  logic                        in_valid,
   input  logic [15:0]                 in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic signed [BIT_WIDTH-1:0] out_data,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        w_loaded,
   output logic                        err
);

   localparam int ACC_W  = calc_acc_w(BIT_WIDTH, IN_LEN);
   localparam int NBEATS = calc_nbeats(IN_LEN, OUT_LEN);
   localparam int NW     = IN_LEN * OUT_LEN;
   localparam int COL_W  = $clog2(IN_LEN);
   localparam int IDX_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   localparam logic signed [BIT_WIDTH-1:0] OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam logic signed [BIT_WIDTH-1:0] OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]     SAT_MAX = ACC_W'(OUT_MAX);
   localparam logic signed [ACC_W-1:0]     SAT_MIN = ACC_W'(OUT_MIN);

   logic [1:0]                  state;
   logic [BC_W-1:0]             beat_cnt;
   logic [COL_W-1:0]            col;
   logic [IDX_W-1:0]            idx;
   logic [2*NW-1:0]             w_mem;
   logic                        accept_in;
   logic                        run_start;
   logic                        mac_en;
   logic signed [BIT_WIDTH-1:0] x;
   logic [1:0]                  row_w   [OUT_LEN];
   logic signed [ACC_W-1:0]     acc_vec [OUT_LEN];
   logic signed [ACC_W-1:0]     acc_sel;
   logic signed [BIT_WIDTH-1:0] sat_val;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign in_ready  = (state == ST_LOAD) || (state == ST_RUN);
   assign out_valid = (state == ST_DRAIN);
   assign accept_in = in_valid && in_ready;
   assign mac_en    = accept_in && (state == ST_RUN);
   assign run_start = cmd_valid && (state == ST_IDLE) && (cmd == CMD_RUN) && w_loaded;
   assign x         = in_data[BIT_WIDTH-1:0];

   // Every row sees column `col` of its own weight row; all rows update together.
   for (genvar r = 0; r < OUT_LEN; r++) begin : g_row
      assign row_w[r] = w_mem[2*(r*IN_LEN + int'(col)) +: 2];

      ternary_mac_row #(
         .BIT_WIDTH (BIT_WIDTH),
         .ACC_W     (ACC_W)
      ) u_row (
         .clk    (clk),
         .rst    (rst),
         .w_code (row_w[r]),
         .x      (x),
         .clear  (run_start),
         .en     (mac_en),
         .acc    (acc_vec[r])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         col      <= '0;
         idx      <= '0;
         w_mem    <= '0;
         w_loaded <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd == CMD_LOAD) begin
                  state    <= ST_LOAD;
                  beat_cnt <= '0;
                  err      <= 1'b0;
                  w_loaded <= 1'b0;
               end else if (cmd_valid && cmd == CMD_RUN) begin
                  if (w_loaded) begin
                     state <= ST_RUN;
                     col   <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (accept_in) begin
                  // Beat b carries weights 8b..8b+7, two bits each, lowest index in the LSBs.
                  w_mem[16*int'(beat_cnt) +: 16] <= in_data;
                  if (beat_cnt == BC_W'(NBEATS-1)) begin
                     w_loaded <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + BC_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (accept_in) begin
                  if (col == COL_W'(IN_LEN-1)) begin
                     state <= ST_DRAIN;
                     idx   <= '0;
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            default: begin
               if (out_ready) begin
                  if (idx == IDX_W'(OUT_LEN-1)) begin
                     state <= ST_IDLE;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign acc_sel = acc_vec[idx];

   // Accumulators are frozen and idx only moves on a handshake, so out_data is stable under backpressure.
   always_comb begin
      sat_val = acc_sel[BIT_WIDTH-1:0];
      if (acc_sel > SAT_MAX) begin
         sat_val = OUT_MAX;
      end else if (acc_sel < SAT_MIN) begin
         sat_val = OUT_MIN;
      end
`ifdef TERNARY_MVM_RELU_EN
      if (sat_val < 0) begin
         sat_val = '0;
      end
`else
`endif
      out_data = (state == ST_DRAIN) ? sat_val : '0;
   end

endmodule

// File: doc/ternary_mvm_core.md
Name: ternary_mvm_core

Overview:
- Parametrised ternary matrix-vector engine. Second generation of the tiny-ternary datapath.
- Adds the following over the first generation:
  - configurable IN_LEN, OUT_LEN and BIT_WIDTH;
  - valid/ready handshakes on command, input and output;
  - saturated, back-pressured result streaming;
  - a return to IDLE after each run, with weights retained for reuse.
- Sits behind the TT pin wrapper; the wrapper maps pins onto the streams.

Parameters:
- IN_LEN, 16: vector length, i.e. matrix columns. Must be a power of two, 2 or more.
- OUT_LEN, 8: matrix rows and number of outputs. IN_LEN*OUT_LEN must be a multiple of 8.
- BIT_WIDTH, 8: width of the signed vector element and of the signed output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset. Clears all state, including weights.
- cmd_valid  in  1  command offered.
- cmd  in  2  command code: 01=LOAD, 10=RUN. 00 and 11 are NOP (accepted, no effect).
- cmd_ready  out  1  high only in IDLE.
- in_valid  in  1  input beat offered.
- in_data  in  16  weight beat (LOAD), or element in [BIT_WIDTH-1:0] (RUN).
- in_ready  out  1  high in LOAD and RUN.
- out_valid  out  1  a result is presented.
- out_data  out  BIT_WIDTH  signed saturated result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.
- w_loaded  out  1  a complete weight load has finished since reset.
- err  out  1  sticky: RUN was issued while w_loaded=0.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0, w_loaded=0, err=0. All weights and accumulators are 0.
- Derived widths:
  - ACC_W = BIT_WIDTH + $clog2(IN_LEN) + 1.
  - NBEATS = IN_LEN*OUT_LEN/8.
- Weight encoding (2 bits): 01=+1, 11=-1, 00=0, 10=0 (reserved, treated as zero).
- Weight index k = row*IN_LEN + col. Beat b carries k = 8b..8b+7; in_data[2i+1:2i] holds weight 8b+i.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - cmd_valid && cmd==LOAD: go to LOAD, clear the beat counter, clear err, clear w_loaded.
  - cmd_valid && cmd==RUN && w_loaded: go to RUN and clear all accumulators.
  - cmd_valid && cmd==RUN && !w_loaded: stay in IDLE and set err.
- LOAD:
  - Each in_valid&&in_ready beat writes 8 weights and increments the counter.
  - The beat that makes the count NBEATS sets w_loaded and returns to IDLE on the next edge.
- RUN:
  - Accepted beat j (0..IN_LEN-1) takes x = signed in_data[BIT_WIDTH-1:0].
  - All OUT_LEN accumulators update in parallel in the same cycle: acc[r] += w[r][j]*x.
  - After beat IN_LEN-1 is accepted, go to DRAIN with output index 0.
- DRAIN:
  - in_ready=0. out_valid=1, and out_data = sat(acc[idx]) (BIT_WIDTH-signed clamp).
  - out_data is held stable while out_ready=0.
  - On each handshake idx increments.
  - The handshake at idx=OUT_LEN-1 returns to IDLE. out_valid is 0 in the following cycle.
- Latency: out_valid rises 1 cycle after the last RUN beat is accepted. With out_ready held high, one result is produced per cycle.
- in_valid while in_ready=0, and cmd_valid while busy, are ignored (no side effects).
- Accumulators cannot overflow at the ACC_W width. Saturation is applied only at the output.
- Weights persist across runs. Multiple RUNs after one LOAD give identical results for identical vectors.
- A LOAD overwrites every weight. An async rst at any point returns to the reset values immediately, including mid-LOAD and mid-DRAIN.

Optional Feature:
- Macro TERNARY_MVM_RELU_EN.
- Defined: out_data = max(0, sat(acc)); negative results are emitted as 0.
- Undefined: signed saturated results are emitted unchanged. Port list is identical in both cases.

Decomposition:
- Package ternary_mvm_pkg:
  - state enum (IDLE/LOAD/RUN/DRAIN);
  - cmd codes (CMD_LOAD=2'b01, CMD_RUN=2'b10);
  - weight codes (W_POS=2'b01, W_NEG=2'b11, W_ZERO=2'b00);
  - the ACC_W and NBEATS computation as a function of the parameters.
- One sub-module, ternary_mac_row: holds one accumulator. Inputs are the row's weight code, x, clear and enable; output is acc. It is instantiated OUT_LEN times.
- The top holds the FSM, the weight store, the counters and the saturating output mux.

Test Plan:
- Default parameters. Reset, then LOAD with 16 beats of 16'h5555 (all +1), then RUN with 16 elements of 3, out_ready held high. Required: out_valid 1 cycle after the last beat; 8 consecutive results of 48; busy falls and cmd_ready returns high.
- Saturation: all +1 weights with x=100 gives 8 outputs of 127. LOAD 16'hFFFF (all -1) with x=100 gives 8 outputs of -128. With TERNARY_MVM_RELU_EN defined, the -1 case gives 8 outputs of 0.
- Identity-style load: w[r][r]=+1, all others 0. Vector x_j = j-8. Required: out r = r-8, i.e. -8..-1. A second RUN without a reload gives the same results.
- Backpressure: toggle out_ready randomly 50%. Required: out_data is stable whenever out_valid&&!out_ready; exactly 8 handshakes occur; no lost or duplicated results.
- RUN directly after reset: err=1 and the state stays IDLE. A following LOAD clears err.
- Reset mid-RUN after 5 beats: asserting rst clears busy, w_loaded and out_valid immediately. A following RUN sets err.
